// File: rtl/buffer_pkg.sv
// Shared helpers for the multi-stage valid/ready buffer: count width and parameter sanity check.
package buffer_pkg;

   function automatic int unsigned f_cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Depth must be a power of two >= 2 so the pointers can wrap naturally.
   function automatic bit f_params_ok(input int unsigned depth, input int unsigned afull);
      return (depth >= 2) && ((depth & (depth - 1)) == 0) && (afull >= 1) && (afull <= depth);
   endfunction

endpackage

// File: rtl/multi_stage_buffer_mem.sv
// Register array for the buffer: one write port, one asynchronous read port, no reset.
module multi_stage_buffer_mem #(
   parameter int unsigned G_DATA_SIZE = 8,
   parameter int unsigned G_DEPTH     = 4,
   localparam int unsigned AW         = $clog2(G_DEPTH)
) (
   input  logic                   clk_i,
   input  logic                   we_i,
   input  logic [AW-1:0]          waddr_i,
   input  logic [G_DATA_SIZE-1:0] wdata_i,
   input  logic [AW-1:0]          raddr_i,
   output logic [G_DATA_SIZE-1:0] rdata_o
);

   logic [G_DATA_SIZE-1:0] mem_q [G_DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/multi_stage_buffer.sv
// First-word-fall-through FIFO with valid/ready on both sides, fill level, almost-full and flush.
module multi_stage_buffer
   import buffer_pkg::*;
#(
   parameter int unsigned G_DATA_SIZE = 8,
   parameter int unsigned G_DEPTH     = 4,
   parameter int unsigned G_AFULL     = G_DEPTH - 1,
   localparam int unsigned CW         = f_cnt_width(G_DEPTH)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   s_valid_i,
   output logic                   s_ready_o,
   input  logic [G_DATA_SIZE-1:0] s_data_i,
   output logic                   m_valid_o,
   input  logic                   m_ready_i,
   output logic [G_DATA_SIZE-1:0] m_data_o,
   output logic [CW-1:0]          fill_o,
   output logic                   afull_o
);

   localparam int unsigned AW = $clog2(G_DEPTH);

   if (!f_params_ok(G_DEPTH, G_AFULL)) begin : g_param_check
      $error("multi_stage_buffer: G_DEPTH must be a power of two >= 2 and G_AFULL in 1..G_DEPTH");
   end

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          s_ready_q, s_ready_d;
   logic          afull_q, afull_d;
   logic          push, pop, we;

   // Ready comes from a register so it never depends on m_ready_i in the same cycle.
   always_comb begin
      push     = s_valid_i && s_ready_q;
      pop      = (count_q != '0) && m_ready_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
      s_ready_d = (count_d != CW'(G_DEPTH));
      afull_d   = (count_d >= CW'(G_AFULL));
      we        = push && !flush_i && rst_ni;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         s_ready_q <= 1'b1;
         afull_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         s_ready_q <= s_ready_d;
         afull_q   <= afull_d;
      end
   end

   multi_stage_buffer_mem #(
      .G_DATA_SIZE (G_DATA_SIZE),
      .G_DEPTH     (G_DEPTH)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (we),
      .waddr_i (wr_ptr_q),
      .wdata_i (s_data_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (m_data_o)
   );

   assign s_ready_o = s_ready_q;
   assign m_valid_o = (count_q != '0);
   assign fill_o    = count_q;
   assign afull_o   = afull_q;

endmodule

// File: tb/tb_multi_stage_buffer.sv
// Directed bench for multi_stage_buffer (depth 4, afull at 3) with hand-computed expectations.
module tb_multi_stage_buffer;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       flush_i;
   logic       s_valid_i;
   logic       s_ready_o;
   logic [7:0] s_data_i;
   logic       m_valid_o;
   logic       m_ready_i;
   logic [7:0] m_data_o;
   logic [2:0] fill_o;
   logic       afull_o;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk_i = ~clk_i;

   multi_stage_buffer #(
      .G_DATA_SIZE (8),
      .G_DEPTH     (4),
      .G_AFULL     (3)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (flush_i),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .s_data_i  (s_data_i),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i),
      .m_data_o  (m_data_o),
      .fill_o    (fill_o),
      .afull_o   (afull_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic rdy, input logic vld,
                            input logic [2:0] fill, input logic af);
      chk({tag, ".s_ready"}, 32'(s_ready_o), 32'(rdy));
      chk({tag, ".m_valid"}, 32'(m_valid_o), 32'(vld));
      chk({tag, ".fill"}, 32'(fill_o), 32'(fill));
      chk({tag, ".afull"}, 32'(afull_o), 32'(af));
   endtask

   initial begin
      logic [7:0] fill_vals [4];
      logic [7:0] drain_vals [4];
      fill_vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
      drain_vals = '{8'hB1, 8'hB2, 8'hB3, 8'hC4};

      rst_ni = 1'b0; flush_i = 1'b0; s_valid_i = 1'b0; s_data_i = 8'h00; m_ready_i = 1'b0;

      // 1. reset and idle
      tick(); chk_flags("rst0", 1'b1, 1'b0, 3'd0, 1'b0);
      tick(); chk_flags("rst1", 1'b1, 1'b0, 3'd0, 1'b0);
      rst_ni = 1'b1;
      tick(); chk_flags("idle0", 1'b1, 1'b0, 3'd0, 1'b0);
      tick(); chk_flags("idle1", 1'b1, 1'b0, 3'd0, 1'b0);

      // 2. fill with consumer stalled, then drain
      for (int i = 0; i < 4; i++) begin
         s_valid_i = 1'b1; s_data_i = fill_vals[i];
         tick();
         chk_flags($sformatf("fill%0d", i), (i != 3), 1'b1, 3'(i + 1), (i >= 2));
         chk($sformatf("fill%0d.head", i), 32'(m_data_o), 32'h11);
      end
      s_valid_i = 1'b0; m_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain%0d.valid", i), 32'(m_valid_o), 32'h1);
         chk($sformatf("drain%0d.data", i), 32'(m_data_o), 32'(fill_vals[i]));
         tick();
      end
      chk_flags("drained", 1'b1, 1'b0, 3'd0, 1'b0);

      // 3. streaming across pointer wrap
      for (int i = 0; i < 10; i++) begin
         s_valid_i = 1'b1; s_data_i = 8'(i);
         tick();
         chk($sformatf("stream%0d.valid", i), 32'(m_valid_o), 32'h1);
         chk($sformatf("stream%0d.data", i), 32'(m_data_o), 32'(i));
         chk($sformatf("stream%0d.fill", i), 32'(fill_o), 32'h1);
      end
      s_valid_i = 1'b0;
      tick(); chk_flags("stream_end", 1'b1, 1'b0, 3'd0, 1'b0);

      // 4. back-pressure hold, then pop at full does not admit a push
      m_ready_i = 1'b0; s_valid_i = 1'b1; s_data_i = 8'hA5;
      tick(); s_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("hold%0d.valid", i), 32'(m_valid_o), 32'h1);
         chk($sformatf("hold%0d.data", i), 32'(m_data_o), 32'hA5);
      end
      for (int i = 0; i < 3; i++) begin
         s_valid_i = 1'b1; s_data_i = drain_vals[i];
         tick();
      end
      chk_flags("full", 1'b0, 1'b1, 3'd4, 1'b1);
      s_data_i = 8'hC4; m_ready_i = 1'b1;
      tick();
      chk_flags("full_pop", 1'b1, 1'b1, 3'd3, 1'b1);
      chk("full_pop.head", 32'(m_data_o), 32'hB1);
      m_ready_i = 1'b0;
      tick();
      chk_flags("late_push", 1'b0, 1'b1, 3'd4, 1'b1);
      s_valid_i = 1'b0; m_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bp_drain%0d", i), 32'(m_data_o), 32'(drain_vals[i]));
         tick();
      end
      chk_flags("bp_drained", 1'b1, 1'b0, 3'd0, 1'b0);

      // 5. flush discards a same-cycle push
      m_ready_i = 1'b0; s_valid_i = 1'b1;
      s_data_i = 8'h51; tick();
      s_data_i = 8'h52; tick();
      s_data_i = 8'h53; tick();
      chk_flags("pre_flush", 1'b1, 1'b1, 3'd3, 1'b1);
      flush_i = 1'b1; s_data_i = 8'h66;
      tick();
      chk_flags("flushed", 1'b1, 1'b0, 3'd0, 1'b0);
      flush_i = 1'b0; s_data_i = 8'h77;
      tick();
      chk_flags("post_flush", 1'b1, 1'b1, 3'd1, 1'b0);
      chk("post_flush.head", 32'(m_data_o), 32'h77);

      // 6. reset while full
      s_data_i = 8'h81; tick();
      s_data_i = 8'h82; tick();
      s_data_i = 8'h83; tick();
      chk_flags("pre_rst", 1'b0, 1'b1, 3'd4, 1'b1);
      s_valid_i = 1'b0; rst_ni = 1'b0;
      tick();
      chk_flags("mid_rst", 1'b1, 1'b0, 3'd0, 1'b0);
      rst_ni = 1'b1; s_valid_i = 1'b1; s_data_i = 8'h90;
      tick();
      s_valid_i = 1'b0;
      chk_flags("after_rst", 1'b1, 1'b1, 3'd1, 1'b0);
      chk("after_rst.head", 32'(m_data_o), 32'h90);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
